// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative 32-cycle shift-add multiplier / restoring divider with stall request
module mcycle_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic [1:0]  MCycleOp,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  output logic [31:0] Result1,
  output logic [31:0] Result2,
  output logic        Busy
);
  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} stateT;
  stateT state, nextState;
  logic [1:0] opReg;
  logic [31:0] op1Reg, op2Reg, hiReg, loReg;
  logic [4:0] count;
  logic isDiv, neg1, neg2, inNeg;
  logic [31:0] mag1, mag2, inSel, inMag, stepHi, stepLo, quo, rem, res1Next, res2Next;
  logic [32:0] mulSum, trial;
  logic [63:0] prod;
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : nextState;
  always_comb
    nextState = state == IDLE      ? (Start ? COMPUTING : IDLE) :
                state == COMPUTING ? (count == 5'd31 ? DONE : COMPUTING) : IDLE;
  always_comb
    Busy = ~RESET & ((state == IDLE & Start) | state == COMPUTING);
  always_comb begin
    inSel    = MCycleOp[1] ? Operand1 : Operand2;
    inNeg    = ~MCycleOp[0] & inSel[31];
    inMag    = inNeg ? -inSel : inSel;
    isDiv    = opReg[1];
    neg1     = ~opReg[0] & op1Reg[31];
    neg2     = ~opReg[0] & op2Reg[31];
    mag1     = neg1 ? -op1Reg : op1Reg;
    mag2     = neg2 ? -op2Reg : op2Reg;
    mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, mag1} : 33'd0);
    trial    = {hiReg, loReg[31]} - {1'b0, mag2};
    stepHi   = isDiv ? (trial[32] ? {hiReg[30:0], loReg[31]} : trial[31:0]) : mulSum[32:1];
    stepLo   = isDiv ? {loReg[30:0], ~trial[32]} : {mulSum[0], loReg[31:1]};
    prod     = (neg1 ^ neg2) ? -{stepHi, stepLo} : {stepHi, stepLo};
    quo      = (neg1 ^ neg2) ? -stepLo : stepLo;
    rem      = neg1 ? -stepHi : stepHi;
    res1Next = !isDiv ? prod[31:0]  : op2Reg == 32'd0 ? 32'hFFFF_FFFF : quo;
    res2Next = !isDiv ? prod[63:32] : op2Reg == 32'd0 ? op1Reg : rem;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      opReg   <= '0;
      op1Reg  <= '0;
      op2Reg  <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      count   <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else if (state == IDLE && Start) begin
      opReg  <= MCycleOp;
      op1Reg <= Operand1;
      op2Reg <= Operand2;
      hiReg  <= '0;
      loReg  <= inMag;
      count  <= '0;
    end else if (state == COMPUTING) begin
      hiReg <= stepHi;
      loReg <= stepLo;
      count <= count + 5'd1;
      if (count == 5'd31) begin
        Result1 <= res1Next;
        Result2 <= res2Next;
      end
    end
  end
endmodule
